// File: rtl/mac_pkg.sv
// Shared types and constants for the digit-serial MAC sequencer.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIG_W  = 2;
  localparam int PROD_W = 4;

  // Width of a counter or index that must hold values 0..n-1 (never below 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_pp_align.sv
// Places one 2x2 partial product at bit offset 2*(i+j) inside an ACC_W-bit word.
module mac_pp_align
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 24,
  parameter int IDX_W = idx_w(W / DIG_W)
) (
  input  logic [PROD_W-1:0] mult_p,
  input  logic [IDX_W-1:0]  i,
  input  logic [IDX_W-1:0]  j,
  output logic [ACC_W-1:0]  pp
);

  logic [IDX_W:0] k;

  // Largest shift is 2W-4, so a 4-bit product always fits in 2W <= ACC_W bits.
  assign k  = {1'b0, i} + {1'b0, j};
  assign pp = ACC_W'(mult_p) << (DIG_W * k);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Digit-serial W x W multiply-accumulate sequencer driving an external 2x2 cell.
// Build option MAC_SAT_EN: saturate acc to all-ones on overflow instead of wrapping.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              acc_clr,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf,
  output logic [DIG_W-1:0]  mult_a,
  output logic [DIG_W-1:0]  mult_b,
  input  logic [PROD_W-1:0] mult_p,
  output state_t            dbg_state
);

  // Handshake: start is taken on any edge where ready is high (IDLE or DONE);
  // while busy, start, a, b and acc_clr are ignored and may change freely.

  localparam int D       = W / DIG_W;
  localparam int N_STEPS = D * D;
  localparam int S_W     = idx_w(N_STEPS);
  localparam int IDX_W   = idx_w(D);
  localparam logic [S_W-1:0] LAST_S = S_W'(N_STEPS - 1);

  state_t            state_q, state_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic [IDX_W-1:0]  i_idx;
  logic [IDX_W-1:0]  j_idx;
  logic [ACC_W-1:0]  pp;
  logic [ACC_W:0]    sum;

  assign i_idx = IDX_W'(s_q / S_W'(D));
  assign j_idx = IDX_W'(s_q % S_W'(D));

  // The cell is combinational, so its product is consumed in the same cycle.
  assign mult_a = (state_q == RUN) ? a_q[DIG_W*i_idx +: DIG_W] : '0;
  assign mult_b = (state_q == RUN) ? b_q[DIG_W*j_idx +: DIG_W] : '0;

  mac_pp_align #(
    .W     (W),
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_pp_align (
    .mult_p (mult_p),
    .i      (i_idx),
    .j      (j_idx),
    .pp     (pp)
  );

  assign sum = {1'b0, acc_q} + {1'b0, pp};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          s_d     = '0;
          state_d = RUN;
          if (acc_clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
`ifdef MAC_SAT_EN
        // Once at all-ones any nonzero addend carries again, so it stays pinned.
        acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc_d = sum[ACC_W-1:0];
`endif
        ovf_d = ovf_q | sum[ACC_W];
        if (s_q == LAST_S) begin
          state_d = DONE;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready     = (state_q != RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign acc       = acc_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed-vector bench for mac_seq_ctrl: 24-bit and 16-bit accumulator instances.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT 0: W=8, ACC_W=24 ----------------
  logic        start0, clr0, ready0, busy0, done0, ovf0;
  logic [7:0]  a0, b0;
  logic [23:0] acc0;
  logic [1:0]  ma0, mb0;
  logic [3:0]  mp0;
  state_t      st0;

  assign mp0 = {2'b00, ma0} * {2'b00, mb0};

  mac_seq_ctrl #(.W(8), .ACC_W(24)) dut (
    .clk (clk), .rst (rst), .start (start0), .acc_clr (clr0),
    .a (a0), .b (b0), .ready (ready0), .busy (busy0), .done (done0),
    .acc (acc0), .ovf (ovf0), .mult_a (ma0), .mult_b (mb0),
    .mult_p (mp0), .dbg_state (st0)
  );

  // ---------------- DUT 1: W=8, ACC_W=16 ----------------
  logic        start1, clr1, ready1, busy1, done1, ovf1;
  logic [7:0]  a1, b1;
  logic [15:0] acc1;
  logic [1:0]  ma1, mb1;
  logic [3:0]  mp1;
  state_t      st1;

  assign mp1 = {2'b00, ma1} * {2'b00, mb1};

  mac_seq_ctrl #(.W(8), .ACC_W(16)) dut16 (
    .clk (clk), .rst (rst), .start (start1), .acc_clr (clr1),
    .a (a1), .b (b1), .ready (ready1), .busy (busy1), .done (done1),
    .acc (acc1), .ovf (ovf1), .mult_a (ma1), .mult_b (mb1),
    .mult_p (mp1), .dbg_state (st1)
  );

`ifdef MAC_SAT_EN
  localparam logic [23:0] EXP16_OVF_A = 24'h00FFFF;
  localparam logic [23:0] EXP16_OVF_B = 24'h00FFFF;
`else
  localparam logic [23:0] EXP16_OVF_A = 24'h00FC02;
  localparam logic [23:0] EXP16_OVF_B = 24'h00FC03;
`endif

  localparam int EXP_LAT = 17;

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        clr;
    logic [23:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic clr);
    if (sel) begin
      start1 = st; a1 = a; b1 = b; clr1 = clr;
    end else begin
      start0 = st; a0 = a; b0 = b; clr0 = clr;
    end
  endtask

  // Launch one operation and wait (bounded) for done. lat counts edges from the
  // cycle start is presented to the cycle done is visible.
  task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic clr,
                        input bit pulse, output int lat, output logic [23:0] acc_r,
                        output logic ovf_r);
    int step;
    @(negedge clk);
    drive(sel, 1'b1, a, b, clr);
    @(posedge clk); #1;
    lat  = 1;
    step = 0;
    check("busy_after_accept", sel ? busy1 : busy0, 1);
    while (lat <= 40) begin
      @(negedge clk);
      drive(sel, pulse && (step == 3 || step == 10), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      lat++;
      step++;
      if (sel ? done1 : done0) break;
    end
    acc_r = sel ? {8'h00, acc1} : acc0;
    ovf_r = sel ? ovf1 : ovf0;
  endtask

  // One cycle without start after DONE: must fall back to IDLE.
  task automatic idle_check(input bit sel);
    @(negedge clk);
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("idle_done_low", sel ? done1 : done0, 0);
    check("idle_ready_high", sel ? ready1 : ready0, 1);
  endtask

  task automatic op_and_check(input string tag, input bit sel, input logic [7:0] a,
                              input logic [7:0] b, input logic clr, input bit pulse,
                              input logic [23:0] exp_acc, input logic exp_ovf);
    int          lat;
    logic [23:0] acc_r;
    logic        ovf_r;
    logic [23:0] e;
    exp_q.push_back(exp_acc);
    run_op(sel, a, b, clr, pulse, lat, acc_r, ovf_r);
    e = exp_q.pop_front();
    check({tag, "_latency"}, lat, EXP_LAT);
    check({tag, "_acc"}, acc_r, e);
    check({tag, "_ovf"}, ovf_r, exp_ovf);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{8'hFF, 8'hFF, 1'b1, 24'h00FE01, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b1, 24'h00000F, 1'b0};
    vecs[2] = '{8'h0A, 8'h0A, 1'b0, 24'h000073, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 1'b1, 24'h0003A8, 1'b0};
    vecs[4] = '{8'h00, 8'hAB, 1'b1, 24'h000000, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 24'h004000, 1'b0};
    vecs[6] = '{8'hFF, 8'h01, 1'b0, 24'h0040FF, 1'b0};
    vecs[7] = '{8'h01, 8'hFF, 1'b0, 24'h0041FE, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b1, 24'h003872, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_acc", acc0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_ready", ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_mult_a", ma0, 0);
    check("rst_mult_b", mb0, 0);
    check("rst_acc16", acc1, 0);

    for (int k = 0; k < 9; k++) begin
      op_and_check($sformatf("vec%0d", k), 1'b0, vecs[k].a, vecs[k].b, vecs[k].clr, 1'b0,
                   vecs[k].exp_acc, vecs[k].exp_ovf);
      idle_check(1'b0);
    end

    // start pulses at RUN steps 3 and 10 must be ignored
    op_and_check("busy_start", 1'b0, 8'h07, 8'h09, 1'b1, 1'b1, 24'h00003F, 1'b0);
    idle_check(1'b0);

    // back-to-back: start presented during DONE restarts with no IDLE cycle
    op_and_check("b2b_first", 1'b0, 8'h03, 8'h03, 1'b1, 1'b0, 24'h000009, 1'b0);
    op_and_check("b2b_second", 1'b0, 8'h02, 8'h02, 1'b1, 1'b0, 24'h000004, 1'b0);
    idle_check(1'b0);

    // asynchronous reset at RUN step 7
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hAB, 8'hCD, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    check("midrun_busy_before_rst", busy0, 1);
    rst = 1'b1;
    #1;
    check("arst_acc", acc0, 0);
    check("arst_ovf", ovf0, 0);
    check("arst_busy", busy0, 0);
    check("arst_done", done0, 0);
    check("arst_ready", ready0, 1);
    check("arst_mult_a", ma0, 0);
    check("arst_mult_b", mb0, 0);
    @(negedge clk);
    rst = 1'b0;
    op_and_check("after_rst", 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 24'h0003A8, 1'b0);
    idle_check(1'b0);

    // 16-bit accumulator: overflow, sticky flag, then clear
    op_and_check("acc16_first", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 24'h00FE01, 1'b0);
    op_and_check("acc16_ovf", 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, EXP16_OVF_A, 1'b1);
    op_and_check("acc16_sticky", 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, EXP16_OVF_B, 1'b1);
    op_and_check("acc16_clear", 1'b1, 8'h03, 8'h05, 1'b1, 1'b0, 24'h00000F, 1'b0);
    idle_check(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
